// File: rtl/fu_alu_vec.sv
// fu_alu_vec: STAGES-deep SIMD integer ALU with per-lane mask, flags and tag pass-through.
// Define ALU_SAT_EN to make ADD/SUB saturate instead of wrapping.

package isa_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module fu_alu_vec
    import isa_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  aluop_t                 aluop,
    input  logic [LANES-1:0]       lane_en,
    input  logic [TAG_W-1:0]       tag_in,
    input  logic [LANES*WIDTH-1:0] port_a,
    input  logic [LANES*WIDTH-1:0] port_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_W-1:0]       tag_out,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       overflow,
    output logic [LANES-1:0]       zero,
    output logic [LANES-1:0]       negative
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    logic                   adv;
    logic [LANES*WIDTH-1:0] res_d;
    logic [LANES-1:0]       ovf_d;
    logic [LANES-1:0]       zero_d;
    logic [LANES-1:0]       neg_d;

    logic [STAGES-1:0]                        valid_q;
    logic [STAGES-1:0][TAG_W-1:0]             tag_q;
    logic [STAGES-1:0][LANES*WIDTH-1:0]       res_q;
    logic [STAGES-1:0][LANES-1:0]             ovf_q;
    logic [STAGES-1:0][LANES-1:0]             zero_q;
    logic [STAGES-1:0][LANES-1:0]             neg_q;

    // The whole pipe moves in lockstep; a stalled output freezes every stage.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    always_comb begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] lane_r;
        logic [SH_W-1:0]  sh;
        logic             v;
        res_d  = '0;
        ovf_d  = '0;
        zero_d = '0;
        neg_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            a    = port_a[i*WIDTH +: WIDTH];
            b    = port_b[i*WIDTH +: WIDTH];
            sh   = b[SH_W-1:0];
            sum  = a + b;
            diff = a - b;
            r    = '0;
            v    = 1'b0;
            case (aluop)
                ALU_SLL:  r = a << sh;
                ALU_SRL:  r = a >> sh;
                ALU_SRA:  r = $signed(a) >>> sh;
                ALU_ADD: begin
                    r = sum;
                    v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                ALU_SUB: begin
                    r = diff;
                    v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                end
                ALU_AND:  r = a & b;
                ALU_OR:   r = a | b;
                ALU_XOR:  r = a ^ b;
                ALU_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                ALU_SLTU: r = {{(WIDTH-1){1'b0}}, a < b};
                default:  r = '0;
            endcase
`ifdef ALU_SAT_EN
            // Overflow direction follows the sign of A for both ADD and SUB.
            if (v) begin
                lane_r = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                lane_r = r;
            end
`else
            lane_r = r;
`endif
            if (lane_en[i]) begin
                res_d[i*WIDTH +: WIDTH] = lane_r;
                ovf_d[i]                = v;
                zero_d[i]               = (lane_r == '0);
                neg_d[i]                = lane_r[WIDTH-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            ovf_q   <= '0;
            zero_q  <= '0;
            neg_q   <= '0;
        end else if (adv) begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= tag_in;
            res_q[0]   <= res_d;
            ovf_q[0]   <= ovf_d;
            zero_q[0]  <= zero_d;
            neg_q[0]   <= neg_d;
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                tag_q[s]   <= tag_q[s-1];
                res_q[s]   <= res_q[s-1];
                ovf_q[s]   <= ovf_q[s-1];
                zero_q[s]  <= zero_q[s-1];
                neg_q[s]   <= neg_q[s-1];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign tag_out   = tag_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign overflow  = ovf_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign negative  = neg_q[STAGES-1];

endmodule

// File: tb/tb_fu_alu_vec.sv
// Self-checking bench for fu_alu_vec: directed corner cases plus randomized traffic
// scored against a wide-arithmetic reference model and an in-order expectation queue.

module tb_fu_alu_vec;
    import isa_pkg::*;

    localparam int W = 32;
    localparam int L = 4;
    localparam int S = 2;
    localparam int T = 4;
    localparam longint MAXS = (longint'(1) <<< (W-1)) - 1;
    localparam longint MINS = -(longint'(1) <<< (W-1));

    typedef struct {
        logic [T-1:0]   tag;
        logic [L*W-1:0] res;
        logic [L-1:0]   ovf;
        logic [L-1:0]   zero;
        logic [L-1:0]   neg;
        int             acc_cyc;
    } exp_t;

    logic           CLK = 1'b0;
    logic           nRST;
    logic           in_valid;
    logic           in_ready;
    aluop_t         aluop;
    logic [L-1:0]   lane_en;
    logic [T-1:0]   tag_in;
    logic [L*W-1:0] port_a;
    logic [L*W-1:0] port_b;
    logic           out_valid;
    logic           out_ready;
    logic [T-1:0]   tag_out;
    logic [L*W-1:0] result;
    logic [L-1:0]   overflow;
    logic [L-1:0]   zero;
    logic [L-1:0]   negative;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    fu_alu_vec #(.WIDTH(W), .LANES(L), .STAGES(S), .TAG_W(T)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .lane_en   (lane_en),
        .tag_in    (tag_in),
        .port_a    (port_a),
        .port_b    (port_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tag_out   (tag_out),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    // Reference model: lanes computed with 64-bit signed arithmetic and range checks.
    function automatic exp_t model(input aluop_t op, input logic [L-1:0] en, input logic [T-1:0] tg,
                                   input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        exp_t e;
        e.tag = tg;
        e.res = '0;
        e.ovf = '0;
        e.zero = '0;
        e.neg = '0;
        e.acc_cyc = 0;
        for (int i = 0; i < L; i++) begin
            logic [W-1:0] ua;
            logic [W-1:0] ub;
            logic [W-1:0] r;
            longint sa;
            longint sb;
            longint full;
            int sh;
            bit o;
            ua = a[i*W +: W];
            ub = b[i*W +: W];
            sa = longint'($signed(ua));
            sb = longint'($signed(ub));
            sh = int'(ub % W);
            full = 0;
            o = 1'b0;
            r = '0;
            case (op)
                ALU_ADD, ALU_SUB: begin
                    full = (op == ALU_ADD) ? sa + sb : sa - sb;
                    o = (full > MAXS) || (full < MINS);
                    r = W'(full);
`ifdef ALU_SAT_EN
                    if (full > MAXS) r = W'(MAXS);
                    if (full < MINS) r = W'(MINS);
`endif
                end
                ALU_SLL:  r = ua << sh;
                ALU_SRL:  r = ua >> sh;
                ALU_SRA:  r = W'(sa >>> sh);
                ALU_AND:  r = ua & ub;
                ALU_OR:   r = ua | ub;
                ALU_XOR:  r = ua ^ ub;
                ALU_SLT:  r = (sa < sb) ? W'(1) : W'(0);
                ALU_SLTU: r = (ua < ub) ? W'(1) : W'(0);
                default:  r = '0;
            endcase
            if (en[i]) begin
                e.res[i*W +: W] = r;
                e.ovf[i]  = o;
                e.zero[i] = (r == 0);
                e.neg[i]  = r[W-1];
            end
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rword();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return W'(MAXS);
            3: return W'(MINS);
            4: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [L*W-1:0] rvec();
        logic [L*W-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = rword();
        return v;
    endfunction

    // Drives one cycle of inputs at the falling edge and reports whether the issue is taken.
    task automatic tick(input logic v, input aluop_t op, input logic [L-1:0] en,
                        input logic [T-1:0] tg, input logic [L*W-1:0] a,
                        input logic [L*W-1:0] b, input logic ordy, output logic acc);
        @(negedge CLK);
        in_valid  = v;
        aluop     = op;
        lane_en   = en;
        tag_in    = tg;
        port_a    = a;
        port_b    = b;
        out_ready = ordy;
        #1;
        cyc++;
        acc = v && in_ready;
    endtask

    // Issues one op into an empty pipe and returns once its result is presented.
    task automatic issue_and_wait(input aluop_t op, input logic [L-1:0] en, input logic [T-1:0] tg,
                                  input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                  output int lat);
        logic acc;
        int c0;
        lat = -1;
        tick(1'b1, op, en, tg, a, b, 1'b1, acc);
        c0 = cyc;
        if (acc) begin
            for (int k = 0; k < 20; k++) begin
                tick(1'b0, ALU_ADD, '0, '0, '0, '0, 1'b1, acc);
                if (out_valid) begin
                    lat = cyc - c0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic acc;
        nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b0; aluop = ALU_ADD;
        lane_en = '0; tag_in = '0; port_a = '0; port_b = '0;
        repeat (3) @(negedge CLK);
        #1;
        n_total++;
        if ({out_valid, tag_out, result, overflow, zero, negative} !== '0) begin
            $display("FAIL reset_outputs: got v=%b tag=%h res=%h, required all zero",
                     out_valid, tag_out, result);
        end else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        tick(1'b1, ALU_ADD, '1, 4'd1, rvec(), rvec(), 1'b1, acc);
        tick(1'b1, ALU_XOR, '1, 4'd2, rvec(), rvec(), 1'b1, acc);
        @(negedge CLK);
        #1;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL inflight_valid: got %b, required 1", out_valid);
        else n_pass++;
        nRST = 1'b0;
        #1;
        n_total++;
        if ({out_valid, tag_out, result} !== '0) begin
            $display("FAIL midreset_clear: got v=%b tag=%h res=%h, required zero",
                     out_valid, tag_out, result);
        end else n_pass++;
        in_valid = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, ALU_ADD, '0, '0, '0, '0, 1'b1, acc);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL post_reset_empty: got %b, required 0", out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_add_ovf();
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [W-1:0] exp_l0;
        logic exp_neg;
        exp_t e;
        int lat;
        a = rvec(); b = rvec();
        a[0 +: W] = 32'h7FFF_FFFF;
        b[0 +: W] = 32'h0000_0001;
`ifdef ALU_SAT_EN
        exp_l0 = 32'h7FFF_FFFF; exp_neg = 1'b0;
`else
        exp_l0 = 32'h8000_0000; exp_neg = 1'b1;
`endif
        e = model(ALU_ADD, '1, 4'd3, a, b);
        issue_and_wait(ALU_ADD, '1, 4'd3, a, b, lat);
        n_total++;
        if (lat !== S) $display("FAIL add_latency: got %0d, required %0d", lat, S);
        else n_pass++;
        n_total++;
        if (result[0 +: W] !== exp_l0) $display("FAIL add_lane0: got %h, required %h", result[0 +: W], exp_l0);
        else n_pass++;
        n_total++;
        if ({overflow[0], negative[0]} !== {1'b1, exp_neg}) begin
            $display("FAIL add_flags: got ovf=%b neg=%b, required 1 %b", overflow[0], negative[0], exp_neg);
        end else n_pass++;
        n_total++;
        if ({tag_out, result, overflow, zero, negative} !== {e.tag, e.res, e.ovf, e.zero, e.neg}) begin
            $display("FAIL add_all_lanes: got %h %h %b %b %b, required %h %h %b %b %b", tag_out, result,
                     overflow, zero, negative, e.tag, e.res, e.ovf, e.zero, e.neg);
        end else n_pass++;
    endtask

    task automatic test_sub_sra();
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [W-1:0] exp_l1;
        int lat;
`ifdef ALU_SAT_EN
        exp_l1 = 32'h8000_0000;
`else
        exp_l1 = 32'h7FFF_FFFF;
`endif
        a = rvec(); b = rvec();
        a[W +: W] = 32'h8000_0000; b[W +: W] = 32'h0000_0001;
        issue_and_wait(ALU_SUB, '1, 4'd4, a, b, lat);
        n_total++;
        if ({result[W +: W], overflow[1]} !== {exp_l1, 1'b1}) begin
            $display("FAIL sub_lane1: got %h ovf=%b, required %h ovf=1", result[W +: W], overflow[1], exp_l1);
        end else n_pass++;
        a[2*W +: W] = 32'hF000_0000; b[2*W +: W] = 32'h0000_0004;
        issue_and_wait(ALU_SRA, '1, 4'd5, a, b, lat);
        n_total++;
        if ({result[2*W +: W], overflow} !== {32'hFF00_0000, 4'b0000}) begin
            $display("FAIL sra_lane2: got %h ovf=%b, required ff000000 ovf=0000", result[2*W +: W], overflow);
        end else n_pass++;
        a[0 +: W] = 32'h0000_0001; b[0 +: W] = 32'hFFFF_FFFF;
        issue_and_wait(ALU_SLTU, '1, 4'd6, a, b, lat);
        n_total++;
        if (result[0 +: W] !== 32'h1) $display("FAIL sltu_lane0: got %h, required 00000001", result[0 +: W]);
        else n_pass++;
        issue_and_wait(ALU_SLT, '1, 4'd7, a, b, lat);
        n_total++;
        if ({result[0 +: W], zero[0]} !== {32'h0, 1'b1}) begin
            $display("FAIL slt_lane0: got %h z=%b, required 00000000 z=1", result[0 +: W], zero[0]);
        end else n_pass++;
    endtask

    task automatic test_mask();
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        int lat;
        a = rvec(); b = rvec();
        a[W +: W] = '0; b[3*W +: W] = '0;  // masked lanes whose AND would be zero
        issue_and_wait(ALU_AND, 4'b0101, 4'd8, a, b, lat);
        n_total++;
        if ({result[W +: W], result[3*W +: W], zero[1], zero[3]} !== '0) begin
            $display("FAIL mask_off_lanes: got %h %h z1=%b z3=%b, required zeros",
                     result[W +: W], result[3*W +: W], zero[1], zero[3]);
        end else n_pass++;
        n_total++;
        if ({result[0 +: W], result[2*W +: W]} !== {a[0 +: W] & b[0 +: W], a[2*W +: W] & b[2*W +: W]}) begin
            $display("FAIL mask_on_lanes: got %h %h, required %h %h", result[0 +: W], result[2*W +: W],
                     a[0 +: W] & b[0 +: W], a[2*W +: W] & b[2*W +: W]);
        end else n_pass++;
        issue_and_wait(aluop_t'(4'd13), '1, 4'd9, rvec(), rvec(), lat);
        n_total++;
        if ({result, overflow, zero, negative} !== {128'h0, 4'b0000, 4'b1111, 4'b0000}) begin
            $display("FAIL undef_op: got %h ovf=%b z=%b n=%b, required 0 0000 1111 0000",
                     result, overflow, zero, negative);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        exp_t h;
        logic acc;
        logic ordy;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        aluop_t op;
        int tx = 1;
        int rx = 0;
        for (int k = 1; k <= 40 && rx < 6; k++) begin
            ordy = !(k >= 3 && k <= 5);
            a = rvec(); b = rvec();
            op = aluop_t'(4'($urandom_range(0, 9)));
            e = model(op, '1, T'(tx), a, b);
            tick(tx <= 6, op, '1, T'(tx), a, b, ordy, acc);
            if (!ordy) begin
                n_total++;
                if ({in_ready, out_valid} !== 2'b01) begin
                    $display("FAIL stall_ready: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
                end else n_pass++;
                n_total++;
                if (q.size() == 0) $display("FAIL stall_hold: got empty queue, required entry");
                else if ({tag_out, result} !== {q[0].tag, q[0].res}) begin
                    $display("FAIL stall_hold: got %h %h, required %h %h", tag_out, result, q[0].tag, q[0].res);
                end else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_total++;
                if (q.size() == 0) $display("FAIL b2b_spurious: got tag %h, required none", tag_out);
                else begin
                    h = q.pop_front();
                    if ({tag_out, result, overflow, zero, negative} !== {T'(rx + 1), h.res, h.ovf, h.zero, h.neg}) begin
                        $display("FAIL b2b_order: got tag %h res %h, required tag %h res %h",
                                 tag_out, result, T'(rx + 1), h.res);
                    end else n_pass++;
                end
                rx++;
            end
            if (acc) begin
                q.push_back(e);
                tx++;
            end
        end
        n_total++;
        if (rx != 6) $display("FAIL b2b_count: got %0d, required 6", rx);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, ALU_ADD, '0, '0, '0, '0, 1'b1, acc);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL b2b_dup: got out_valid %b, required 0", out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_throughput();
        exp_t q[$];
        exp_t e;
        exp_t h;
        logic acc;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        aluop_t op;
        int sent = 0;
        for (int k = 0; k < 60 && (sent < 20 || q.size() > 0); k++) begin
            a = rvec(); b = rvec();
            op = aluop_t'(4'($urandom_range(0, 9)));
            e = model(op, '1, T'(sent), a, b);
            tick(sent < 20, op, '1, T'(sent), a, b, 1'b1, acc);
            if (sent < 20) begin
                n_total++;
                if (acc !== 1'b1) $display("FAIL tput_accept: got in_ready %b, required 1", in_ready);
                else n_pass++;
            end
            if (out_valid) begin
                n_total++;
                if (q.size() == 0) $display("FAIL tput_spurious: got tag %h, required none", tag_out);
                else begin
                    h = q.pop_front();
                    if ({tag_out, result} !== {h.tag, h.res} || (cyc - h.acc_cyc) != S) begin
                        $display("FAIL tput_latency: got tag %h lat %0d, required tag %h lat %0d",
                                 tag_out, cyc - h.acc_cyc, h.tag, S);
                    end else n_pass++;
                end
            end
            if (acc) begin
                e.acc_cyc = cyc;
                q.push_back(e);
                sent++;
            end
        end
        n_total++;
        if (q.size() != 0 || sent != 20) $display("FAIL tput_drain: got %0d left, required 0", q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t h;
        logic acc;
        logic v;
        logic ordy;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [L-1:0] en;
        logic [T-1:0] tg;
        aluop_t op;
        int sent = 0;
        for (int k = 0; k < 2000 && (sent < 150 || q.size() > 0); k++) begin
            v = (sent < 150) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a = rvec(); b = rvec();
            en = L'($urandom);
            tg = T'($urandom);
            op = aluop_t'(4'($urandom_range(0, 15)));
            e = model(op, en, tg, a, b);
            tick(v, op, en, tg, a, b, ordy, acc);
            if (out_valid) begin
                n_total++;
                if (q.size() == 0) $display("FAIL rand_spurious: got tag %h, required none", tag_out);
                else begin
                    h = q[0];
                    if ({tag_out, result, overflow, zero, negative} !== {h.tag, h.res, h.ovf, h.zero, h.neg}) begin
                        $display("FAIL rand_result: got %h %h %b %b %b, required %h %h %b %b %b", tag_out,
                                 result, overflow, zero, negative, h.tag, h.res, h.ovf, h.zero, h.neg);
                    end else n_pass++;
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (acc) begin
                q.push_back(e);
                sent++;
            end
        end
        n_total++;
        if (q.size() != 0 || sent != 150) $display("FAIL rand_drain: got %0d left, required 0", q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub_sra();
        test_mask();
        test_back_to_back();
        test_throughput();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
